// File: rtl/fpga_pkg.sv
// Shared types and sizing helpers for the FPGA fabric blocks.
// Build option FPGA_BLE_FF_EN adds the BLE output flip-flop and its ff_sel config bit.
package fpga_pkg;

   localparam int BLE_K_MIN = 2;
   localparam int BLE_K_MAX = 6;

   typedef enum logic [1:0] {
      UNCFG = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2
   } ble_state_e;

   // Config chain length per BLE: truth table plus the optional ff_sel bit.
   function automatic int cfg_len(input int k);
`ifdef FPGA_BLE_FF_EN
      return (1 << k) + 1;
`else
      return (1 << k);
`endif
   endfunction

endpackage

// File: rtl/fpga_lut_mux.sv
// Pure 2**K:1 lookup mux; the table entry addressed by i_sel drives o_bit.
module fpga_lut_mux #(
   parameter int K = 4
) (
   input  logic [(2**K)-1:0] i_table,
   input  logic [K-1:0]      i_sel,
   output logic              o_bit
);

   assign o_bit = i_table[i_sel];

endmodule

// File: rtl/fpga_ble.sv
// K-input basic logic element: LUT, optional output FF, serial config shift chain.
// Build option FPGA_BLE_FF_EN enables the output flip-flop and the ff_sel config bit.
module fpga_ble
   import fpga_pkg::*;
#(
   parameter int K = 4
) (
   input  logic         clk_i,
   input  logic         reset_ni,
   input  logic         cfg_en_i,
   input  logic         cfg_valid_i,
   input  logic         cfg_bit_i,
   output logic         cfg_ready_o,
   output logic         cfg_valid_o,
   output logic         cfg_bit_o,
   output logic         cfg_done_o,
   input  logic [K-1:0] in_i,
   input  logic         ff_en_i,
   output logic         out_o
);

   localparam int TBL_LEN = 2 ** K;
   localparam int CFG_LEN = cfg_len(K);
   localparam int CNT_W   = $clog2(CFG_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   if (K < BLE_K_MIN || K > BLE_K_MAX) begin : g_k_range
      $error("fpga_ble: K outside supported range");
   end

   ble_state_e         r_state;
   ble_state_e         w_state_nxt;
   logic [CFG_LEN-1:0] r_cfg;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_load;
   logic               w_run;
   logic               w_accept;
   logic               w_enter_load;
   logic               w_lut;
   logic               w_out_run;

   assign w_load       = (r_state == LOAD);
   assign w_run        = (r_state == RUN);
   assign w_accept     = cfg_valid_i & w_load;
   assign w_enter_load = cfg_en_i & ~w_load;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state <= UNCFG;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // A restart in LOAD still takes the bit presented in the same cycle as bit 1.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         UNCFG: begin
            if (cfg_en_i) begin
               w_state_nxt = LOAD;
               w_cnt_nxt   = '0;
            end
         end
         LOAD: begin
            if (cfg_en_i) begin
               w_cnt_nxt = w_accept ? CNT_ONE : '0;
            end else if (w_accept) begin
               if (r_cnt == CNT_LAST) begin
                  w_state_nxt = RUN;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
               end
            end
         end
         RUN: begin
            if (cfg_en_i) begin
               w_state_nxt = LOAD;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = UNCFG;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_cfg <= '0;
      end else if (w_accept) begin
         r_cfg <= {r_cfg[CFG_LEN-2:0], cfg_bit_i};
      end
   end

   fpga_lut_mux #(
      .K(K)
   ) u_lut_mux (
      .i_table(r_cfg[TBL_LEN-1:0]),
      .i_sel  (in_i),
      .o_bit  (w_lut)
   );

`ifdef FPGA_BLE_FF_EN
   logic r_ff;

   // Entering LOAD wipes the FF so a reconfigured BLE never shows a stale registered value.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_ff <= 1'b0;
      end else if (w_enter_load) begin
         r_ff <= 1'b0;
      end else if (w_run && ff_en_i) begin
         r_ff <= w_lut;
      end
   end

   assign w_out_run = r_cfg[TBL_LEN] ? r_ff : w_lut;
`else
   logic w_unused_ff_en;
   assign w_unused_ff_en = ff_en_i;
   assign w_out_run      = w_lut;
`endif

   assign cfg_ready_o = w_load;
   assign cfg_valid_o = w_accept;
   assign cfg_bit_o   = r_cfg[CFG_LEN-1];
   assign cfg_done_o  = w_run;
   assign out_o       = w_run & w_out_run;

endmodule

// File: tb/tb_fpga_ble.sv
// Self-checking bench for fpga_ble: two chained BLEs, randomized tables, behavioural output model.
// Follows the FPGA_BLE_FF_EN build option of the design.
module tb_fpga_ble;

`ifdef FPGA_BLE_FF_EN
   localparam bit HAS_FF = 1'b1;
`else
   localparam bit HAS_FF = 1'b0;
`endif
   localparam int K       = 4;
   localparam int TBL     = 16;
   localparam int CFG_LEN = TBL + (HAS_FF ? 1 : 0);

   logic         clk      = 1'b0;
   logic         reset_ni = 1'b0;
   logic         cfg_en   = 1'b0;
   logic         cfg_valid = 1'b0;
   logic         cfg_bit  = 1'b0;
   logic         ff_en    = 1'b0;
   logic [K-1:0] in_sel   = '0;

   logic a_ready, a_valid_o, a_bit_o, a_done, a_out;
   logic b_ready, b_valid_o, b_bit_o, b_done, b_out;

   int checks = 0;
   int errors = 0;
   int acc_a  = 0;

   // Reference model: what the BLE was told to be, not how it is built.
   logic [TBL-1:0] m_tbl   = '0;
   logic           m_ffsel = 1'b0;
   logic           m_ff    = 1'b0;
   logic           m_run   = 1'b0;

   always #5 clk = ~clk;

   fpga_ble #(.K(K)) u_a (
      .clk_i(clk), .reset_ni(reset_ni), .cfg_en_i(cfg_en), .cfg_valid_i(cfg_valid),
      .cfg_bit_i(cfg_bit), .cfg_ready_o(a_ready), .cfg_valid_o(a_valid_o),
      .cfg_bit_o(a_bit_o), .cfg_done_o(a_done), .in_i(in_sel), .ff_en_i(ff_en),
      .out_o(a_out)
   );

   fpga_ble #(.K(K)) u_b (
      .clk_i(clk), .reset_ni(reset_ni), .cfg_en_i(cfg_en), .cfg_valid_i(a_valid_o),
      .cfg_bit_i(a_bit_o), .cfg_ready_o(b_ready), .cfg_valid_o(b_valid_o),
      .cfg_bit_o(b_bit_o), .cfg_done_o(b_done), .in_i(in_sel), .ff_en_i(ff_en),
      .out_o(b_out)
   );

   always @(negedge clk) begin
      if (cfg_valid && a_ready) acc_a <= acc_a + 1;
   end

   function automatic logic model_out(input logic [K-1:0] s);
      if (!m_run) return 1'b0;
      if (HAS_FF && m_ffsel) return m_ff;
      return m_tbl[s];
   endfunction

   function automatic logic [CFG_LEN-1:0] mk_bits(input logic [TBL-1:0] tbl, input logic ffsel);
      logic [TBL:0] full;
      full = {ffsel, tbl};
      return full[CFG_LEN-1:0];
   endfunction

   task automatic pulse_en();
      cfg_en    = 1'b1;
      cfg_valid = 1'b0;
      @(posedge clk); #1;
      cfg_en = 1'b0;
      m_run  = 1'b0;
      m_ff   = 1'b0;
   endtask

   // Sends n bits MSB-first from the top of 'bits', holding each until accepted.
   task automatic send_bits(input logic [CFG_LEN-1:0] bits, input int n, input bit stall,
                            input bit en_first);
      int sent  = 0;
      int guard = 0;
      bit first = en_first;
      while (sent < n && guard < 300) begin
         cfg_valid = !stall || ($urandom_range(1, 0) == 1);
         cfg_bit   = cfg_valid ? bits[CFG_LEN-1-sent] : 1'($urandom_range(1, 0));
         cfg_en    = first && cfg_valid;
         @(negedge clk);
         if (cfg_valid && a_ready) begin
            sent++;
            first = 1'b0;
         end
         @(posedge clk); #1;
         cfg_en = 1'b0;
         guard++;
      end
      cfg_valid = 1'b0;
      if (sent < n) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: accepted %0d bits, required %0d", sent, n);
      end
   endtask

   task automatic load_cfg(input logic [TBL-1:0] tbl, input logic ffsel, input bit stall);
      pulse_en();
      send_bits(mk_bits(tbl, ffsel), CFG_LEN, stall, 1'b0);
      m_tbl   = tbl;
      m_ffsel = ffsel;
      m_ff    = 1'b0;
      m_run   = 1'b1;
   endtask

   task automatic test_reset();
      reset_ni = 1'b0;
      for (int c = 0; c < 4; c++) begin
         cfg_en    = 1'($urandom);
         cfg_valid = 1'b1;
         cfg_bit   = 1'($urandom);
         in_sel    = 4'($urandom);
         ff_en     = 1'($urandom);
         @(negedge clk);
         checks++;
         if ({a_ready, a_valid_o, a_bit_o, a_done, a_out} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 00000",
                     {a_ready, a_valid_o, a_bit_o, a_done, a_out});
         end
         @(posedge clk); #1;
      end
      cfg_en    = 1'b0;
      cfg_valid = 1'b1;
      ff_en     = 1'b0;
      reset_ni  = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if ({a_ready, a_valid_o, a_done, a_out} !== 4'b0) begin
            errors++;
            $display("FAIL uncfg_ignores_bits: ready/valid/done/out %b, required 0000",
                     {a_ready, a_valid_o, a_done, a_out});
         end
         @(posedge clk); #1;
      end
      cfg_valid = 1'b0;
      m_run = 1'b0;
      m_ff  = 1'b0;
   endtask

   task automatic test_and4();
      logic [CFG_LEN-1:0] bits;
      logic [CFG_LEN-1:0] lastw;
      bits  = mk_bits(16'h8000, 1'b0);
      lastw = bits << (CFG_LEN - 1);
      pulse_en();
      @(negedge clk);
      checks++;
      if (a_ready !== 1'b1 || a_done !== 1'b0) begin
         errors++;
         $display("FAIL load_entry: ready %b done %b, required ready 1 done 0", a_ready, a_done);
      end
      @(posedge clk); #1;
      send_bits(bits, CFG_LEN - 1, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (a_done !== 1'b0 || a_ready !== 1'b1) begin
         errors++;
         $display("FAIL done_early: done %b ready %b, required done 0 ready 1", a_done, a_ready);
      end
      @(posedge clk); #1;
      send_bits(lastw, 1, 1'b0, 1'b0);
      m_tbl = 16'h8000; m_ffsel = 1'b0; m_ff = 1'b0; m_run = 1'b1;
      in_sel = 4'hF;
      @(negedge clk);
      checks++;
      if (a_done !== 1'b1 || a_ready !== 1'b0) begin
         errors++;
         $display("FAIL done_after_load: done %b ready %b, required done 1 ready 0", a_done, a_ready);
      end
      checks++;
      if (a_bit_o !== bits[CFG_LEN-1]) begin
         errors++;
         $display("FAIL chain_msb: cfg_bit_o %b, required %b", a_bit_o, bits[CFG_LEN-1]);
      end
      checks++;
      if (a_out !== model_out(4'hF)) begin
         errors++;
         $display("FAIL and4_F: out %b, required %b", a_out, model_out(4'hF));
      end
      @(posedge clk); #1;
      in_sel    = 4'hE;
      cfg_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (a_out !== model_out(4'hE)) begin
         errors++;
         $display("FAIL and4_E: out %b, required %b", a_out, model_out(4'hE));
      end
      checks++;
      if (a_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL run_valid_o: cfg_valid_o %b, required 0", a_valid_o);
      end
      @(posedge clk); #1;
      cfg_valid = 1'b0;
   endtask

   task automatic test_ff_xor();
      load_cfg(16'h6996, 1'b1, 1'b0);
      in_sel = 4'h1;
      ff_en  = 1'b1;
      @(negedge clk);
      checks++;
      if (a_out !== model_out(in_sel)) begin
         errors++;
         $display("FAIL xor_pre_capture: out %b, required %b", a_out, model_out(in_sel));
      end
      m_ff = m_tbl[in_sel];
      @(posedge clk); #1;
      ff_en  = 1'b0;
      in_sel = 4'h3;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (a_out !== model_out(in_sel)) begin
            errors++;
            $display("FAIL xor_hold_%0d: out %b, required %b", c, a_out, model_out(in_sel));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall();
      int acc0;
      logic [TBL-1:0] tbl;
      logic ffsel;
      tbl   = 16'($urandom);
      ffsel = 1'($urandom);
      acc0  = acc_a;
      load_cfg(tbl, ffsel, 1'b1);
      @(negedge clk);
      checks++;
      if (acc_a - acc0 !== CFG_LEN) begin
         errors++;
         $display("FAIL stall_accepts: counted %0d, required %0d", acc_a - acc0, CFG_LEN);
      end
      checks++;
      if (a_done !== 1'b1) begin
         errors++;
         $display("FAIL stall_done: done %b, required 1", a_done);
      end
      @(posedge clk); #1;
      for (int c = 0; c < 20; c++) begin
         in_sel = 4'($urandom);
         ff_en  = 1'($urandom);
         @(negedge clk);
         checks++;
         if (a_out !== model_out(in_sel)) begin
            errors++;
            $display("FAIL stall_out in=%h: out %b, required %b", in_sel, a_out, model_out(in_sel));
         end
         if (ff_en) m_ff = m_tbl[in_sel];
         @(posedge clk); #1;
      end
      ff_en = 1'b0;
   endtask

   task automatic test_restart();
      logic [CFG_LEN-1:0] bits;
      logic [CFG_LEN-1:0] lastw;
      logic [TBL-1:0] tbl;
      tbl   = 16'($urandom);
      bits  = mk_bits(tbl, 1'b0);
      lastw = bits << (CFG_LEN - 1);
      pulse_en();
      send_bits(CFG_LEN'($urandom), 5, 1'b0, 1'b0);
      send_bits(bits, CFG_LEN - 1, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (a_done !== 1'b0) begin
         errors++;
         $display("FAIL restart_count: done %b after %0d restarted bits, required 0", a_done, CFG_LEN - 1);
      end
      @(posedge clk); #1;
      send_bits(lastw, 1, 1'b0, 1'b0);
      m_tbl = tbl; m_ffsel = 1'b0; m_ff = 1'b0; m_run = 1'b1;
      for (int i = 0; i < TBL; i++) begin
         in_sel = 4'(i);
         @(negedge clk);
         checks++;
         if (a_out !== model_out(in_sel)) begin
            errors++;
            $display("FAIL restart_out in=%h: out %b, required %b", in_sel, a_out, model_out(in_sel));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_load();
      load_cfg(16'hA5C3, 1'b1, 1'b0);
      pulse_en();
      send_bits(mk_bits(16'h5AF0, 1'b1), 8, 1'b0, 1'b0);
      #2;
      reset_ni = 1'b0;
      #1;
      checks++;
      if ({a_ready, a_bit_o, a_done, a_out} !== 4'b0) begin
         errors++;
         $display("FAIL async_reset: ready/bit/done/out %b, required 0000",
                  {a_ready, a_bit_o, a_done, a_out});
      end
      @(posedge clk); #1;
      reset_ni = 1'b1;
      m_run = 1'b0; m_ff = 1'b0;
      @(negedge clk);
      checks++;
      if (a_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_to_uncfg: ready %b, required 0", a_ready);
      end
      @(posedge clk); #1;
      load_cfg(16'hFFFF, 1'b0, 1'b0);
      for (int i = 0; i < TBL; i++) begin
         in_sel = 4'(i);
         @(negedge clk);
         checks++;
         if (a_out !== model_out(in_sel)) begin
            errors++;
            $display("FAIL ones_out in=%h: out %b, required %b", in_sel, a_out, model_out(in_sel));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reconfig();
      load_cfg(16'h8000, 1'b1, 1'b0);
      in_sel = 4'hF;
      ff_en  = 1'b1;
      @(posedge clk); #1;
      m_ff  = m_tbl[4'hF];
      ff_en = 1'b0;
      @(negedge clk);
      checks++;
      if (a_out !== model_out(in_sel)) begin
         errors++;
         $display("FAIL reconf_before: out %b, required %b", a_out, model_out(in_sel));
      end
      @(posedge clk); #1;
      pulse_en();
      @(negedge clk);
      checks++;
      if ({a_out, a_ready, a_done} !== 3'b010) begin
         errors++;
         $display("FAIL reconf_load: out/ready/done %b, required 010", {a_out, a_ready, a_done});
      end
      @(posedge clk); #1;
      load_cfg(16'hFFFE, 1'b1, 1'b0);
      in_sel = 4'h1;
      @(negedge clk);
      checks++;
      if (a_out !== model_out(in_sel)) begin
         errors++;
         $display("FAIL reconf_ff_cleared: out %b, required %b", a_out, model_out(in_sel));
      end
      @(posedge clk); #1;
      load_cfg(16'hFFFE, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         in_sel = 4'(i);
         @(negedge clk);
         checks++;
         if (a_out !== model_out(in_sel)) begin
            errors++;
            $display("FAIL or4_out in=%h: out %b, required %b", in_sel, a_out, model_out(in_sel));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_chain();
      logic [TBL-1:0] ta;
      logic [TBL-1:0] tb;
      ta = 16'($urandom);
      tb = ~ta ^ 16'($urandom_range(255, 1));
      pulse_en();
      send_bits(mk_bits(tb, 1'b0), CFG_LEN, 1'b0, 1'b0);
      pulse_en();
      send_bits(mk_bits(ta, 1'b0), CFG_LEN, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (a_done !== 1'b1 || b_done !== 1'b1) begin
         errors++;
         $display("FAIL chain_done: a %b b %b, required 1 1", a_done, b_done);
      end
      @(posedge clk); #1;
      for (int i = 0; i < TBL; i++) begin
         in_sel = 4'(i);
         @(negedge clk);
         checks++;
         if (a_out !== ta[i] || b_out !== tb[i]) begin
            errors++;
            $display("FAIL chain_out in=%h: a %b b %b, required a %b b %b",
                     in_sel, a_out, b_out, ta[i], tb[i]);
         end
         @(posedge clk); #1;
      end
      m_tbl = ta; m_ffsel = 1'b0; m_ff = 1'b0; m_run = 1'b1;
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         load_cfg(16'($urandom), 1'($urandom), 1'($urandom));
         for (int c = 0; c < 25; c++) begin
            in_sel = 4'($urandom);
            ff_en  = 1'($urandom);
            @(negedge clk);
            checks++;
            if (a_out !== model_out(in_sel)) begin
               errors++;
               $display("FAIL random_out it=%0d in=%h: out %b, required %b",
                        it, in_sel, a_out, model_out(in_sel));
            end
            if (ff_en) m_ff = m_tbl[in_sel];
            @(posedge clk); #1;
         end
         ff_en = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_and4();
      test_ff_xor();
      test_stall();
      test_restart();
      test_reset_mid_load();
      test_reconfig();
      test_chain();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpga_ble.md
# fpga_ble

Parametrised K-input basic logic element (BLE) for the FPGA fabric: a 2^K-entry lookup table, an optional output flip-flop, and a serial configuration shift chain with a valid/ready handshake. The chain is daisy-chainable so a column of BLEs loads from one bitstream port. Sits inside the logic cluster; the cluster config controller drives `cfg_*`, the routing network drives `in_i` and consumes `out_o`.

## Interface
- `K`, 4, LUT input count (2..6); table size `2**K`
- `clk_i`  in  1  fabric/config clock
- `reset_ni`  in  1  one clock; reset is asynchronous and active-low
- `cfg_en_i`  in  1  start (or restart) configuration load
- `cfg_valid_i`  in  1  `cfg_bit_i` valid
- `cfg_bit_i`  in  1  serial config bit
- `cfg_ready_o`  out  1  BLE accepts config bits (high only in LOAD)
- `cfg_valid_o`  out  1  downstream valid = `cfg_valid_i & cfg_ready_o`
- `cfg_bit_o`  out  1  chain out = MSB of config shift register
- `cfg_done_o`  out  1  high in RUN
- `in_i`  in  K  LUT select inputs
- `ff_en_i`  in  1  output flip-flop capture enable
- `out_o`  out  1  BLE output

## Operation
- Config register `cfg_q` length `CFG_LEN` = `2**K + 1` with FF feature, `2**K` without. Layout: `cfg_q[2**K-1:0]` = truth table, entry i = output for `in_i == i`; `cfg_q[2**K]` = `ff_sel` (FF feature only).
- Bit order: first bit sent lands in MSB. Send `ff_sel` first, then table entry `2**K-1` down to entry 0.
- FSM states UNCFG, LOAD, RUN:
  - UNCFG (reset state): `cfg_ready_o=0`, `cfg_done_o=0`, `out_o=0`. `cfg_en_i` -> LOAD.
  - LOAD: `cfg_ready_o=1`. Each accepted bit (`cfg_valid_i & cfg_ready_o`): `cfg_q <= {cfg_q[CFG_LEN-2:0], cfg_bit_i}`, counter++. On the accept that brings counter to `CFG_LEN` -> RUN, counter cleared. `cfg_en_i` in LOAD restarts the counter at 0 (same-cycle bit still accepted and counted as bit 1); `cfg_q` not cleared.
  - RUN: `cfg_done_o=1`. `cfg_en_i` -> LOAD (reconfiguration); `cfg_q` retained until overwritten.
- Counter width `$clog2(CFG_LEN+1)`.
- `out_o` outside RUN = 0. In RUN: `ff_sel=0` -> `lut = cfg_q[in_i]` combinationally; `ff_sel=1` -> flip-flop value.
- Flip-flop: captures `lut` on edge where state is RUN and `ff_en_i=1`; holds otherwise; cleared to 0 on entering LOAD.
- Bits presented while `cfg_ready_o=0` are ignored; `cfg_valid_o=0`.
- `X`/unknown-free: no latches; every output driven in every state.

## Timing
- Reset values: state UNCFG, `cfg_q=0`, counter 0, FF 0; hence `cfg_ready_o=0`, `cfg_valid_o=0`, `cfg_bit_o=0`, `cfg_done_o=0`, `out_o=0`.
- `cfg_en_i` sampled at edge n -> `cfg_ready_o=1` from cycle n+1.
- Full load takes `CFG_LEN` accepted bits; `cfg_done_o` and valid `out_o` from the cycle after the last accept.
- Combinational path `in_i` -> `out_o` zero latency; FF path one cycle after `ff_en_i` edge.
- `cfg_bit_o` is a register output; shifts once per accept, giving a 1-bit-per-BLE chain with zero added cycles.
- Reset mid-LOAD: immediate return to UNCFG, partial config discarded.

## Configuration
- `FPGA_BLE_FF_EN` defined: output FF, `ff_en_i` functional, `CFG_LEN = 2**K+1`, `ff_sel` bit present.
- Undefined: no FF, `ff_en_i` ignored, `CFG_LEN = 2**K`, `out_o` always combinational in RUN. Bitstream format changes accordingly; both builds must be consistent across the chain.

## Structure
- `fpga_pkg`: state enum `ble_state_e` (UNCFG, LOAD, RUN), `cfg_len(K)` function, K bounds constants.
- Sub-module `fpga_lut_mux`: pure `2**K`:1 mux, parameter K, inputs table and select, output bit; reused by other cluster blocks.

## Test plan
- Reset: hold `reset_ni=0` with random inputs -> all outputs 0; `cfg_ready_o=0` ignores `cfg_valid_i=1`.
- K=4, FF build: load `ff_sel=0`, table `16'h8000` (AND4) -> 17 accepts, `cfg_done_o` next cycle; `in_i=4'hF` -> `out_o=1`, `4'hE` -> 0.
- Same with `ff_sel=1`, table `16'h6996` (XOR4): `in_i=4'h1`, `ff_en_i=1` -> `out_o=1` one cycle later; `ff_en_i=0`, `in_i=4'h3` -> `out_o` holds 1.
- Stalls: `cfg_valid_i` toggling 50 % during load -> exactly 17 accepts counted, same result; two chained BLEs loaded with 34 bits -> each holds its own table.
- Reset asserted after 8 of 17 bits -> UNCFG; reload of `16'hFFFF` -> `out_o=1` for all `in_i`.
- Reconfiguration: RUN with AND4, pulse `cfg_en_i` -> `out_o=0`, FF cleared during LOAD; load OR4 (`16'hFFFE`) -> `in_i=4'h1` gives 1.
